// File: rtl/mm_bridge.sv
// Cache line <-> 32-bit memory bus bridge: one 256-bit fill/eviction per command as an 8-beat burst.
// Optional critical-word-first read ordering selected by `define MM_BRIDGE_CWF_EN.
module mm_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BEATS           = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  mm_a,
  input  logic [255:0] mm_wd,
  input  logic         mm_write,
  input  logic         mm_read,
  output logic [255:0] mm_rd,
  output logic         mm_valid,
  output logic         mm_wack,
  output logic         mm_busy,
  output logic         mm_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_a,
  output logic [31:0]  mem_wd,
  input  logic         mem_gnt,
  input  logic [31:0]  mem_rd,
  input  logic         mem_rvalid
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state, state_nx;
  logic [26:0]       line_q;
  logic [2:0]        start_q;
  logic [7:0][31:0]  wbuf_q;
  logic [7:0][31:0]  lbuf_q;
  logic [7:0][31:0]  lbuf_nx;
  logic [255:0]      rd_q;
  logic [3:0]        iss_cnt;
  logic [3:0]        ret_cnt;
  logic [3:0]        out_cnt;
  logic              valid_q, wack_q;
  logic              acc_wr, acc_rd, gnt_fire, rv_fire, wr_last, rd_last;
  logic [2:0]        iss_beat, ret_slot;
  logic              unused;

  assign unused = ^{mm_a[1:0], start_q};

  assign mem_req  = (state == WR) ||
                    ((state == RD) && (iss_cnt < 4'(BEATS)) && (out_cnt < 4'(MAX_OUTSTANDING)));
  assign mem_we   = (state == WR);
  assign mem_a    = (state == IDLE) ? '0 : {line_q, iss_beat, 2'b00};
  assign mem_wd   = (state == WR) ? wbuf_q[iss_cnt[2:0]] : '0;
  assign mm_busy  = (state != IDLE);
  assign mm_err   = (state == IDLE) && mm_read && mm_write;
  assign mm_valid = valid_q;
  assign mm_wack  = wack_q;
  assign mm_rd    = rd_q;

  always_comb begin
    acc_wr   = (state == IDLE) && mm_write;
    acc_rd   = (state == IDLE) && mm_read && !mm_write;
    gnt_fire = mem_req && mem_gnt;
    // Returns with nothing outstanding are stale responses and must not touch the line.
    rv_fire  = (state == RD) && mem_rvalid && (out_cnt != '0);
    wr_last  = (state == WR) && gnt_fire && (iss_cnt == 4'(BEATS - 1));
    rd_last  = rv_fire && (ret_cnt == 4'(BEATS - 1));
`ifdef MM_BRIDGE_CWF_EN
    iss_beat = (state == RD) ? start_q + iss_cnt[2:0] : iss_cnt[2:0];
    ret_slot = start_q + ret_cnt[2:0];
`else
    iss_beat = iss_cnt[2:0];
    ret_slot = ret_cnt[2:0];
`endif
    lbuf_nx = lbuf_q;
    if (rv_fire) lbuf_nx[ret_slot] = mem_rd;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc_wr) state_nx = WR;
               else if (acc_rd) state_nx = RD;
      WR:      if (wr_last) state_nx = IDLE;
      RD:      if (rd_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q  <= '0;
      start_q <= '0;
      wbuf_q  <= '0;
      lbuf_q  <= '0;
      rd_q    <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
      out_cnt <= '0;
      valid_q <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      valid_q <= rd_last;
      wack_q  <= wr_last;
      if (acc_wr || acc_rd) begin
        line_q  <= mm_a[31:5];
        start_q <= mm_a[4:2];
        iss_cnt <= '0;
        ret_cnt <= '0;
        out_cnt <= '0;
        if (acc_wr) wbuf_q <= mm_wd;
      end else begin
        if (gnt_fire) iss_cnt <= iss_cnt + 4'd1;
        if (rv_fire)  ret_cnt <= ret_cnt + 4'd1;
        lbuf_q <= lbuf_nx;
        if (rd_last) rd_q <= lbuf_nx;
        case ({gnt_fire && (state == RD), rv_fire})
          2'b10:   out_cnt <= out_cnt + 4'd1;
          2'b01:   out_cnt <= out_cnt - 4'd1;
          default: out_cnt <= out_cnt;
        endcase
      end
    end
  end

endmodule
